t01_ai_board_scorer: RTL and testbench

- Downstream of the AI placement engine.
- Consumes candidate placements (merged 200-bit board plus rotation and x) one at a time over a valid/ready handshake, instead of holding all 40 boards in parallel.
- Scores each board with a fixed-weight heuristic: lines cleared, aggregate height, holes and bumpiness.
- Tracks the best candidate in the current batch and reports its rotation and x to the AI move controller when the batch's last candidate has been scored.

---
 rtl/t01_ai_board_scorer_if.sv | 29 ++
 rtl/t01_ai_board_scorer.sv | 202 ++++++++++++++++++++
 tb/tb_t01_ai_board_scorer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t01_ai_board_scorer_if.sv
// Candidate handshake and best-move result bundle between the AI placement
// engine (master) and the board scorer (slave).
interface t01_ai_board_scorer_if;
    logic               in_valid;
    logic               in_ready;
    logic [199:0]       in_board;
    logic [1:0]         in_rotation;
    logic [3:0]         in_x;
    logic               in_first;
    logic               in_last;
    logic [1:0]         best_rotation;
    logic [3:0]         best_x;
    logic [5:0]         best_index;
    logic signed [19:0] best_score;
    logic               result_valid;
    logic               done;

    modport master (
        output in_valid, in_board, in_rotation, in_x, in_first, in_last,
        input  in_ready, best_rotation, best_x, best_index, best_score,
        input  result_valid, done
    );

    modport slave (
        input  in_valid, in_board, in_rotation, in_x, in_first, in_last,
        output in_ready, best_rotation, best_x, best_index, best_score,
        output result_valid, done
    );
endinterface

// File: rtl/t01_ai_board_scorer.sv
// Scores candidate boards one row per cycle and keeps the best of each batch.
// Optional feature macro: AI_SCORE_BUMP_EN (bumpiness term in the score).
module t01_ai_board_scorer #(
    parameter logic [7:0] W_LINES  = 8'd76,
    parameter logic [7:0] W_HEIGHT = 8'd51,
    parameter logic [7:0] W_HOLES  = 8'd36,
    parameter logic [7:0] W_BUMP   = 8'd18
) (
    input logic                  clk,
    input logic                  reset,
    t01_ai_board_scorer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, SCORE, COMPARE} state_t;

    state_t             state_reg, state_next;
    logic [199:0]       board_reg;
    logic [1:0]         rot_reg;
    logic [3:0]         x_reg;
    logic               first_reg;
    logic               last_reg;
    logic               batch_open_reg;
    logic [4:0]         row_reg;
    logic [5:0]         index_reg;
    logic [4:0]         lines_reg;
    logic [7:0]         holes_reg;
    logic               seen_reg   [10];
    logic [4:0]         height_reg [10];
    logic signed [19:0] score_reg;
    logic [1:0]         best_rot_reg;
    logic [3:0]         best_x_reg;
    logic [5:0]         best_index_reg;
    logic signed [19:0] best_score_reg;
    logic               result_valid_reg;
    logic               done_reg;

    logic               accept;
    logic               first_eff;
    logic [9:0]         row_bits;
    logic               row_full;
    logic [3:0]         row_holes;
    logic [7:0]         agg;
    logic signed [19:0] score_calc;

    localparam logic signed [19:0] WL_S = 20'(W_LINES);
    localparam logic signed [19:0] WH_S = 20'(W_HEIGHT);
    localparam logic signed [19:0] WO_S = 20'(W_HOLES);

    assign accept    = bus.in_valid && (state_reg == IDLE);
    // Without an open batch the candidate starts one regardless of in_first.
    assign first_eff = bus.in_first || !batch_open_reg;
    // The board shifts down by a row each SCAN cycle, so the current row is always at the bottom bits.
    assign row_bits  = board_reg[9:0];
    assign row_full  = &row_bits;

    always_comb begin
        row_holes = '0;
        agg       = '0;
        for (int c = 0; c < 10; c++) begin
            if (!row_bits[c] && seen_reg[c])
                row_holes = row_holes + 4'd1;
            agg = agg + {3'b000, height_reg[c]};
        end
    end

`ifdef AI_SCORE_BUMP_EN
    logic [4:0]         diff_abs [9];
    logic [7:0]         bump;
    localparam logic signed [19:0] WB_S = 20'(W_BUMP);

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_bump
            assign diff_abs[gi] = (height_reg[gi] >= height_reg[gi+1])
                                ? (height_reg[gi] - height_reg[gi+1])
                                : (height_reg[gi+1] - height_reg[gi]);
        end
    endgenerate

    always_comb begin
        bump = '0;
        for (int c = 0; c < 9; c++)
            bump = bump + {3'b000, diff_abs[c]};
    end

    assign score_calc = WL_S * $signed({15'b0, lines_reg})
                      - WH_S * $signed({12'b0, agg})
                      - WO_S * $signed({12'b0, holes_reg})
                      - WB_S * $signed({12'b0, bump});
`else
    // W_BUMP carries no weight in this build.
    logic [7:0] unused_w_bump;
    assign unused_w_bump = W_BUMP;

    assign score_calc = WL_S * $signed({15'b0, lines_reg})
                      - WH_S * $signed({12'b0, agg})
                      - WO_S * $signed({12'b0, holes_reg});
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SCAN;
            SCAN:    if (row_reg == 5'd19) state_next = SCORE;
            SCORE:   state_next = COMPARE;
            COMPARE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_col
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    seen_reg[gi]   <= 1'b0;
                    height_reg[gi] <= '0;
                end else if (accept) begin
                    seen_reg[gi]   <= 1'b0;
                    height_reg[gi] <= '0;
                end else if (state_reg == SCAN && row_bits[gi] && !seen_reg[gi]) begin
                    seen_reg[gi]   <= 1'b1;
                    height_reg[gi] <= 5'd20 - row_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            board_reg        <= '0;
            rot_reg          <= '0;
            x_reg            <= '0;
            first_reg        <= 1'b0;
            last_reg         <= 1'b0;
            batch_open_reg   <= 1'b0;
            row_reg          <= '0;
            index_reg        <= '0;
            lines_reg        <= '0;
            holes_reg        <= '0;
            score_reg        <= '0;
            best_rot_reg     <= '0;
            best_x_reg       <= '0;
            best_index_reg   <= '0;
            best_score_reg   <= '0;
            result_valid_reg <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        board_reg      <= bus.in_board;
                        rot_reg        <= bus.in_rotation;
                        x_reg          <= bus.in_x;
                        first_reg      <= first_eff;
                        last_reg       <= bus.in_last;
                        batch_open_reg <= 1'b1;
                        index_reg      <= first_eff ? 6'd0 : index_reg + 6'd1;
                        row_reg        <= '0;
                        lines_reg      <= '0;
                        holes_reg      <= '0;
                        if (first_eff)
                            result_valid_reg <= 1'b0;
                    end
                end
                SCAN: begin
                    board_reg <= board_reg >> 10;
                    row_reg   <= row_reg + 5'd1;
                    lines_reg <= lines_reg + {4'b0000, row_full};
                    holes_reg <= holes_reg + {4'b0000, row_holes};
                end
                SCORE: score_reg <= score_calc;
                COMPARE: begin
                    // Strictly greater: on a tie the earlier candidate stays best.
                    if (first_reg || (score_reg > best_score_reg)) begin
                        best_rot_reg   <= rot_reg;
                        best_x_reg     <= x_reg;
                        best_index_reg <= index_reg;
                        best_score_reg <= score_reg;
                    end
                    if (last_reg) begin
                        result_valid_reg <= 1'b1;
                        done_reg         <= 1'b1;
                        batch_open_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = (state_reg == IDLE);
    assign bus.best_rotation = best_rot_reg;
    assign bus.best_x        = best_x_reg;
    assign bus.best_index    = best_index_reg;
    assign bus.best_score    = best_score_reg;
    assign bus.result_valid  = result_valid_reg;
    assign bus.done          = done_reg;
endmodule

// File: tb/tb_t01_ai_board_scorer.sv
// Self-checking bench for t01_ai_board_scorer: directed scenarios plus random
// batches scored by a column-wise reference model.
module tb_t01_ai_board_scorer;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   done_cnt;

    t01_ai_board_scorer_if bus();

    t01_ai_board_scorer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference score from the board rules directly: column tops, cells below tops, full rows.
    function automatic int model_score(input logic [199:0] b);
        int h[10];
        int lines, agg, holes, bump, cnt;
        lines = 0; agg = 0; holes = 0; bump = 0;
        for (int c = 0; c < 10; c++) begin
            h[c] = 0;
            for (int r = 19; r >= 0; r--)
                if (b[r*10+c]) h[c] = 20 - r;
            for (int r = 20 - h[c] + 1; r < 20; r++)
                if (h[c] > 0 && !b[r*10+c]) holes++;
            agg += h[c];
        end
        for (int r = 0; r < 20; r++) begin
            cnt = 0;
            for (int c = 0; c < 10; c++) if (b[r*10+c]) cnt++;
            if (cnt == 10) lines++;
        end
`ifdef AI_SCORE_BUMP_EN
        for (int c = 0; c < 9; c++)
            bump += (h[c] > h[c+1]) ? h[c] - h[c+1] : h[c+1] - h[c];
`endif
        return 76*lines - 51*agg - 36*holes - 18*bump;
    endfunction

    function automatic logic [199:0] rand_board();
        logic [199:0] b;
        int top;
        b = '0;
        top = $urandom_range(0, 20);
        for (int r = top; r < 20; r++) begin
            case ($urandom_range(0, 3))
                0:       b[r*10 +: 10] = 10'h000;
                1:       b[r*10 +: 10] = 10'h3ff;
                default: b[r*10 +: 10] = 10'($urandom);
            endcase
        end
        return b;
    endfunction

    task automatic send(input logic [199:0] b, input logic [1:0] r, input logic [3:0] x,
                        input logic f, input logic l);
        int waitc;
        waitc = 0;
        while (bus.in_ready !== 1'b1 && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (waitc >= 100) begin
            tests++; fails++;
            $display("FAIL ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_board = b; bus.in_rotation = r; bus.in_x = x;
        bus.in_first = f; bus.in_last = l; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_scored();
        repeat (22) @(posedge clk);
        #1;
    endtask

    task automatic check_best(input string name, input int exp_score, input logic [5:0] exp_idx,
                              input logic [1:0] exp_rot, input logic [3:0] exp_x);
        logic signed [19:0] exp_s;
        exp_s = 20'(exp_score);
        tests++;
        if (bus.best_score !== exp_s || bus.best_index !== exp_idx ||
            bus.best_rotation !== exp_rot || bus.best_x !== exp_x || bus.result_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s: got score=%0d idx=%0d rot=%0d x=%0d rv=%b required score=%0d idx=%0d rot=%0d x=%0d rv=1",
                     name, bus.best_score, bus.best_index, bus.best_rotation, bus.best_x,
                     bus.result_valid, exp_s, exp_idx, exp_rot, exp_x);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.done !== 1'b0 || bus.result_valid !== 1'b0 ||
            bus.best_score !== 20'sd0 || bus.best_index !== 6'd0 ||
            bus.best_rotation !== 2'd0 || bus.best_x !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: ready=%b done=%b rv=%b score=%0d idx=%0d rot=%0d x=%0d required ready=1 rest 0",
                     bus.in_ready, bus.done, bus.result_valid, bus.best_score,
                     bus.best_index, bus.best_rotation, bus.best_x);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty_timing();
        send('0, 2'd2, 4'd5, 1'b1, 1'b1);
        repeat (21) @(posedge clk);
        #1;
        tests++;
        if (bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL early_done: done=%b ready=%b at E+22 required 0 0", bus.done, bus.in_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.done !== 1'b1 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL done_timing: done=%b ready=%b at E+23 required 1 1", bus.done, bus.in_ready);
        end
        check_best("empty_board", 0, 6'd0, 2'd2, 4'd5);
        @(posedge clk); #1;
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse_width: done=%b required 0", bus.done);
        end
    endtask

    task automatic test_row_full();
        logic [199:0] b;
        b = '0;
        b[190 +: 10] = 10'h3ff;
        send(b, 2'd1, 4'd3, 1'b1, 1'b1);
        wait_scored();
        check_best("row19_full", -434, 6'd0, 2'd1, 4'd3);
    endtask

    task automatic test_hole();
        logic [199:0] b;
        b = '0;
        b[180] = 1'b1;
        send(b, 2'd3, 4'd0, 1'b1, 1'b1);
        wait_scored();
`ifdef AI_SCORE_BUMP_EN
        check_best("single_hole", -174, 6'd0, 2'd3, 4'd0);
`else
        check_best("single_hole", -138, 6'd0, 2'd3, 4'd0);
`endif
    endtask

    task automatic test_batch_tie();
        logic [199:0] b;
        int d0;
        b = '0;
        b[190 +: 10] = 10'h3ff;
        d0 = done_cnt;
        send('0, 2'd0, 4'd1, 1'b1, 1'b0);
        tests++;
        if (bus.result_valid !== 1'b0) begin
            fails++;
            $display("FAIL rv_clear_on_first: rv=%b required 0", bus.result_valid);
        end
        wait_scored();
        send(b, 2'd1, 4'd2, 1'b0, 1'b0);
        wait_scored();
        send('0, 2'd2, 4'd7, 1'b0, 1'b1);
        wait_scored();
        check_best("batch3_tie", 0, 6'd0, 2'd0, 4'd1);
        tests++;
        if (done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL batch3_done_count: got %0d pulses required 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [199:0] b;
        int low;
        b = '0;
        b[190 +: 10] = 10'h3ff;
        send(b, 2'd0, 4'd4, 1'b1, 1'b0);
        bus.in_board = '0; bus.in_rotation = 2'd1; bus.in_x = 4'd9;
        bus.in_first = 1'b0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        low = 0;
        for (int i = 0; i < 30 && bus.in_ready !== 1'b1; i++) begin
            low++;
            @(posedge clk); #1;
        end
        tests++;
        if (low != 22) begin
            fails++;
            $display("FAIL ready_low_cycles: got %0d required 22", low);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL held_accept: ready=%b after E+23 required 0", bus.in_ready);
        end
        wait_scored();
        check_best("back_to_back", 0, 6'd1, 2'd1, 4'd9);
    endtask

    task automatic test_reset_mid();
        logic [199:0] b;
        int d0;
        send(rand_board(), 2'd3, 4'd6, 1'b1, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.done !== 1'b0 || bus.result_valid !== 1'b0 ||
            bus.best_score !== 20'sd0 || bus.best_index !== 6'd0 ||
            bus.best_rotation !== 2'd0 || bus.best_x !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs: ready=%b done=%b rv=%b score=%0d idx=%0d rot=%0d x=%0d required ready=1 rest 0",
                     bus.in_ready, bus.done, bus.result_valid, bus.best_score,
                     bus.best_index, bus.best_rotation, bus.best_x);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        tests++;
        if (done_cnt != d0) begin
            fails++;
            $display("FAIL mid_reset_no_done: got %0d pulses required 0", done_cnt - d0);
        end
        b = rand_board();
        send(b, 2'd2, 4'd8, 1'b1, 1'b1);
        wait_scored();
        check_best("after_reset", model_score(b), 6'd0, 2'd2, 4'd8);
    endtask

    task automatic test_random_batches();
        logic [199:0] b;
        logic [1:0]   r, best_r;
        logic [3:0]   x, best_x;
        int n, s, best_s, best_i, d0;
        for (int batch = 0; batch < 8; batch++) begin
            n = $urandom_range(1, 6);
            d0 = done_cnt;
            best_s = 0; best_i = 0; best_r = 0; best_x = 0;
            for (int k = 0; k < n; k++) begin
                b = rand_board();
                if (k == 1 && $urandom_range(0, 1) == 1) b = '0;
                r = 2'($urandom);
                x = 4'($urandom_range(0, 9));
                s = model_score(b);
                if (k == 0 || s > best_s) begin
                    best_s = s; best_i = k; best_r = r; best_x = x;
                end
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send(b, r, x, k == 0, k == n - 1);
                wait_scored();
            end
            check_best($sformatf("random_batch%0d", batch), best_s, 6'(best_i), best_r, best_x);
            tests++;
            if (done_cnt - d0 != 1) begin
                fails++;
                $display("FAIL random_batch%0d_done_count: got %0d required 1", batch, done_cnt - d0);
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0; done_cnt = 0;
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_board = '0; bus.in_rotation = '0;
        bus.in_x = '0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        test_reset();
        test_empty_timing();
        test_row_full();
        test_hole();
        test_batch_tie();
        test_back_to_back();
        test_reset_mid();
        test_random_batches();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
